next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/npc_pkg.sv | 17 +
 rtl/npc_prio_sel.sv | 27 ++
 rtl/next_pc_unit.sv | 135 +++++++++++++
 tb/tb_next_pc_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared defaults and the next-PC source encoding for the next_pc_unit slice.
package npc_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int INC_DEF      = 4;
    localparam int RESET_PC_DEF = 0;
    localparam int NSRC_DEF     = 3;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        SRC_SEQ   = 2'd0,
        SRC_REDIR = 2'd1,
        SRC_PEND  = 2'd2,
        SRC_HOLD  = 2'd3
    } npc_src_e;

endpackage

// File: rtl/npc_prio_sel.sv
// Combinational priority encoder and mux over the redirect sources; index 0 wins.
module npc_prio_sel
    import npc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NSRC  = NSRC_DEF
) (
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*WIDTH-1:0] src_addr,
    output logic                  sel_hit,
    output logic [WIDTH-1:0]      sel_addr,
    output logic                  multi
);

    // Walk sources upward; the first valid one is taken, any later valid one flags a conflict.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        multi    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            multi    = multi | (src_valid[i] & sel_hit);
            sel_addr = (src_valid[i] && !sel_hit) ? src_addr[i*WIDTH +: WIDTH] : sel_addr;
            sel_hit  = sel_hit | src_valid[i];
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection: prioritised redirects, a one-deep pending slot captured under stall,
// and sequential increment. Optional redirect counter enabled by NEXT_PC_REDIRECT_CNT_EN.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter int               NSRC     = NSRC_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int               INC      = INC_DEF,
    parameter int               CNT_W    = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*WIDTH-1:0] src_addr,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pcNext,
    output logic                  redirect_taken,
    output logic                  pend_valid,
    output logic                  multi_err
`ifdef NEXT_PC_REDIRECT_CNT_EN
    ,
    output logic [CNT_W-1:0]      redirect_cnt
`endif
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic             sel_hit_s;
    logic [WIDTH-1:0] sel_addr_s;
    logic             multi_s;
    logic             take_s;
    npc_src_e         src_s;
    logic [WIDTH-1:0] pc_next_s;

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pend_addr_r;
    logic             pend_valid_r;
    logic             redirect_taken_r;
    logic             multi_err_r;

    npc_prio_sel #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_prio_sel (
        .src_valid (src_valid),
        .src_addr  (src_addr),
        .sel_hit   (sel_hit_s),
        .sel_addr  (sel_addr_s),
        .multi     (multi_s)
    );

    assign take_s = !stall && (sel_hit_s || pend_valid_r);

    // Decide where the next PC comes from; a live redirect beats the pending target.
    always_comb begin
        src_s = SRC_SEQ;
        if (stall) begin
            src_s = SRC_HOLD;
        end else if (sel_hit_s) begin
            src_s = SRC_REDIR;
        end else if (pend_valid_r) begin
            src_s = SRC_PEND;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Next-PC mux; reset forces RESET_PC so pcNext matches what the edge will load.
    always_comb begin
        pc_next_s = pc_r + INC_W;
        if (rst) begin
            pc_next_s = RESET_PC;
        end else begin
            case (src_s)
                SRC_HOLD:  pc_next_s = pc_r;
                SRC_REDIR: pc_next_s = sel_addr_s;
                SRC_PEND:  pc_next_s = pend_addr_r;
                SRC_SEQ:   pc_next_s = pc_r + INC_W;
                default:   pc_next_s = pc_r + INC_W;
            endcase
        end
    end

    // PC, pending slot and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r             <= RESET_PC;
            pend_addr_r      <= '0;
            pend_valid_r     <= 1'b0;
            redirect_taken_r <= 1'b0;
            multi_err_r      <= 1'b0;
        end else begin
            pc_r             <= pc_next_s;
            redirect_taken_r <= take_s;
            multi_err_r      <= multi_s;
            if (stall && sel_hit_s) begin
                pend_addr_r  <= sel_addr_s;
                pend_valid_r <= 1'b1;
            end else if (stall) begin
                pend_addr_r  <= pend_addr_r;
                pend_valid_r <= pend_valid_r;
            end else begin
                pend_addr_r  <= pend_addr_r;
                pend_valid_r <= 1'b0;
            end
        end
    end

    assign pc             = pc_r;
    assign pcNext         = pc_next_s;
    assign redirect_taken = redirect_taken_r;
    assign pend_valid     = pend_valid_r;
    assign multi_err      = multi_err_r;

`ifdef NEXT_PC_REDIRECT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] redirect_cnt_r;

    // Saturating count of edges that load a redirect or pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_r <= '0;
        end else if (take_s && (redirect_cnt_r != CNT_MAX)) begin
            redirect_cnt_r <= redirect_cnt_r + CNT_W'(1);
        end else begin
            redirect_cnt_r <= redirect_cnt_r;
        end
    end

    assign redirect_cnt = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Table-driven bench for next_pc_unit: directed vectors plus short multi-cycle sequences.
module tb_next_pc_unit;

    localparam int TB_CNT_W = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  src_valid;
    logic [95:0] src_addr;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        redirect_taken;
    logic        pend_valid;
    logic        multi_err;
`ifdef NEXT_PC_REDIRECT_CNT_EN
    logic [TB_CNT_W-1:0] redirect_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    next_pc_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .src_valid      (src_valid),
        .src_addr       (src_addr),
        .pc             (pc),
        .pcNext         (pcNext),
        .redirect_taken (redirect_taken),
        .pend_valid     (pend_valid),
        .multi_err      (multi_err)
`ifdef NEXT_PC_REDIRECT_CNT_EN
        ,
        .redirect_cnt   (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  sv;
        logic [31:0] a2;
        logic [31:0] a1;
        logic [31:0] a0;
        logic [31:0] e_pcnext;
        logic [31:0] e_pc;
        logic        e_rt;
        logic        e_pend;
        logic        e_me;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic [2:0] sv,
                                logic [31:0] a2, logic [31:0] a1, logic [31:0] a0,
                                logic [31:0] pcn, logic [31:0] epc,
                                logic rt, logic pend, logic me);
        vec_t v;
        v.rst = r; v.stall = s; v.sv = sv; v.a2 = a2; v.a1 = a1; v.a0 = a0;
        v.e_pcnext = pcn; v.e_pc = epc; v.e_rt = rt; v.e_pend = pend; v.e_me = me;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [2:0] sv,
                         input logic [31:0] a2, input logic [31:0] a1, input logic [31:0] a0);
        rst = r; stall = s; src_valid = sv; src_addr = {a2, a1, a0};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

        //              rst   stall sv      a2         a1         a0           pcNext       pc          rt    pend  me
        vecs.push_back(mk(1'b1, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h0,       32'h0,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h4,       32'h4,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h8,       32'h8,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'hC,       32'hC,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b110, 32'h200,   32'h100,   32'h0,       32'h100,     32'h100,    1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h104,     32'h104,    1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b100, 32'h40,    32'h0,     32'h0,       32'h104,     32'h104,    1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 32'h0,     32'h0,     32'h0,       32'h104,     32'h104,    1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b000, 32'h0,     32'h0,     32'h0,       32'h104,     32'h104,    1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h40,      32'h40,     1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b100, 32'h40,    32'h0,     32'h0,       32'h40,      32'h40,     1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b010, 32'h0,     32'h60,    32'h0,       32'h40,      32'h40,     1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h60,      32'h60,     1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b100, 32'h40,    32'h0,     32'h0,       32'h60,      32'h60,     1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b001, 32'h0,     32'h0,     32'h80,      32'h80,      32'h80,     1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h84,      32'h84,     1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b011, 32'h0,     32'h20,    32'h10,      32'h84,      32'h84,     1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h10,      32'h10,     1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b001, 32'h0,     32'h0,     32'hFFFFFFFC,32'hFFFFFFFC,32'hFFFFFFFC,1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h0,       32'h0,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h4,       32'h4,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'b100, 32'h40,    32'h0,     32'h0,       32'h4,       32'h4,      1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 3'b001, 32'h0,     32'h0,     32'h80,      32'h0,       32'h0,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h4,       32'h4,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 3'b011, 32'h0,     32'h30,    32'h50,      32'h0,       32'h0,      1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 3'b000, 32'h0,     32'h0,     32'h0,       32'h4,       32'h4,      1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].sv, vecs[i].a2, vecs[i].a1, vecs[i].a0);
            #1;
            chk("pcNext", i, pcNext, vecs[i].e_pcnext);
            @(posedge clk);
            #1;
            chk("pc", i, pc, vecs[i].e_pc);
            chk("redirect_taken", i, {31'd0, redirect_taken}, {31'd0, vecs[i].e_rt});
            chk("pend_valid", i, {31'd0, pend_valid}, {31'd0, vecs[i].e_pend});
            chk("multi_err", i, {31'd0, multi_err}, {31'd0, vecs[i].e_me});
        end

        // multi_err follows each cycle: two conflicting cycles, then one clean one
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b101, 32'h300, 32'h0, 32'h500);
        @(posedge clk); #1;
        chk("seq_me_1", 0, {31'd0, multi_err}, 32'd1);
        chk("seq_pc_1", 0, pc, 32'h500);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b110, 32'h300, 32'h700, 32'h0);
        @(posedge clk); #1;
        chk("seq_me_2", 0, {31'd0, multi_err}, 32'd1);
        chk("seq_pend_2", 0, {31'd0, pend_valid}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        chk("seq_pcnext_3", 0, pcNext, 32'h700);
        @(posedge clk); #1;
        chk("seq_me_3", 0, {31'd0, multi_err}, 32'd0);
        chk("seq_pc_3", 0, pc, 32'h700);

`ifdef NEXT_PC_REDIRECT_CNT_EN
        // Counter saturation: 2^CNT_W + 5 consecutive redirects
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("cnt_reset", 0, 32'(redirect_cnt), 32'd0);
        for (int k = 0; k < (1 << TB_CNT_W) + 5; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 3'b001, 32'h0, 32'h0, 32'h1000 + 32'(k) * 32'h10);
            @(posedge clk); #1;
            if (k == 2) chk("cnt_3", k, 32'(redirect_cnt), 32'd3);
        end
        chk("cnt_sat", 0, 32'(redirect_cnt), 32'((1 << TB_CNT_W) - 1));
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
